// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder: finds the canonical ARM rotated-immediate (imm8, rot4)
// for a 32-bit constant, optionally via its NOT or NEG, plus shifter carry.
module arm_imm_encoder #(
  parameter int ROT_STEPS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [1:0]  in_mode,
  input  logic        in_cf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_encodable,
  output logic [1:0]  out_variant,
  output logic [7:0]  out_imm8,
  output logic [3:0]  out_rot4,
  output logic        out_cf
);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    SEARCH,
    DONE
  } state_t;

  localparam logic [3:0] ROT_LAST = 4'(ROT_STEPS - 1);

  state_t      state;
  logic [31:0] cand;
  logic [31:0] alt;
  logic [3:0]  rot;
  logic        phase;
  logic [1:0]  mode;
  logic        cf_q;

  logic [63:0] dbl;
  logic [31:0] t;
  logic        hit;

  // Rotate the candidate left by 2*rot; a hit means it fits in imm8.
  always_comb begin
    dbl = {cand, cand} << {rot, 1'b0};
    t   = dbl[63:32];
    hit = (t[31:8] == 24'd0);
  end

  // Request capture, alternate-operand prep, rotation search, result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_encodable <= 1'b0;
      out_variant   <= 2'b00;
      out_imm8      <= 8'd0;
      out_rot4      <= 4'd0;
      out_cf        <= 1'b0;
      cand          <= 32'd0;
      alt           <= 32'd0;
      rot           <= 4'd0;
      phase         <= 1'b0;
      mode          <= 2'b00;
      cf_q          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cand     <= in_value;
            mode     <= (in_mode == 2'b11) ? 2'b00 : in_mode;
            cf_q     <= in_cf;
            rot      <= 4'd0;
            phase    <= 1'b0;
            in_ready <= 1'b0;
            state    <= PREP;
          end
        end
        PREP: begin
          // Second-phase operand is built once, before the search starts.
          alt   <= (mode == 2'b01) ? ~cand : (~cand + 32'd1);
          state <= SEARCH;
        end
        SEARCH: begin
          if (hit) begin
            out_encodable <= 1'b1;
            out_imm8      <= t[7:0];
            out_rot4      <= rot;
            out_variant   <= phase ? mode : 2'b00;
            out_cf        <= (rot == 4'd0) ? cf_q : cand[31];
            out_valid     <= 1'b1;
            state         <= DONE;
          end else if (rot != ROT_LAST) begin
            rot <= rot + 4'd1;
          end else if (!phase && (mode != 2'b00)) begin
            phase <= 1'b1;
            rot   <= 4'd0;
            cand  <= alt;
          end else begin
            out_encodable <= 1'b0;
            out_imm8      <= 8'd0;
            out_rot4      <= 4'd0;
            out_variant   <= 2'b00;
            out_cf        <= 1'b0;
            out_valid     <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_imm_encoder.sv
// tb_arm_imm_encoder: directed vectors pushed to a scoreboard queue,
// popped and compared by an independent output monitor.
module tb_arm_imm_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [1:0]  in_mode;
  logic        in_cf;
  logic        out_valid;
  logic        out_ready;
  logic        out_encodable;
  logic [1:0]  out_variant;
  logic [7:0]  out_imm8;
  logic [3:0]  out_rot4;
  logic        out_cf;

  arm_imm_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_value      (in_value),
    .in_mode       (in_mode),
    .in_cf         (in_cf),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_encodable (out_encodable),
    .out_variant   (out_variant),
    .out_imm8      (out_imm8),
    .out_rot4      (out_rot4),
    .out_cf        (out_cf)
  );

  typedef struct {
    logic       enc;
    logic [1:0] vr;
    logic [7:0] imm;
    logic [3:0] rot;
    logic       cf;
    int         lat;
    int         acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          seen = 0;
  logic [15:0] held;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: latency on first valid, stability while held, fields on pop.
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (out_valid) begin
      chk("in_ready_low_in_done", in_ready, 0);
      if (!seen) begin
        seen = 1;
        held = {out_encodable, out_variant, out_imm8, out_rot4, out_cf};
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result imm8=%0h", out_imm8);
        end else begin
          chk("latency", cyc - sb[0].acc, sb[0].lat);
        end
      end else begin
        chk("stable_outputs",
            {out_encodable, out_variant, out_imm8, out_rot4, out_cf},
            held);
      end
      if (out_ready) begin
        seen = 0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("encodable", out_encodable, e.enc);
          chk("variant", out_variant, e.vr);
          chk("imm8", out_imm8, e.imm);
          chk("rot4", out_rot4, e.rot);
          chk("cf", out_cf, e.cf);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [31:0] v, input logic [1:0] m,
                      input logic c, input logic en, input logic [1:0] vr,
                      input logic [7:0] imm, input logic [3:0] rt,
                      input logic cf, input int lat, input bit push);
    exp_t x;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      return;
    end
    in_valid = 1;
    in_value = v;
    in_mode  = m;
    in_cf    = c;
    @(posedge clk);
    #1;
    in_valid = 0;
    if (push) begin
      x.enc = en;
      x.vr  = vr;
      x.imm = imm;
      x.rot = rt;
      x.cf  = cf;
      x.lat = lat;
      x.acc = cyc;
      sb.push_back(x);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 0;
    in_valid = 0;
    in_value = 0;
    in_mode = 0;
    in_cf = 0;
    out_ready = 1;
    #1 rst = 1;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields",
        {out_encodable, out_variant, out_imm8, out_rot4, out_cf}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // value, mode, cf, enc, variant, imm8, rot4, cf_out, latency
    send(32'h000000FF, 2'b00, 1, 1, 2'b00, 8'hFF, 4'd0,  1, 2,  1);
    send(32'hFF000000, 2'b00, 0, 1, 2'b00, 8'hFF, 4'd4,  1, 6,  1);
    send(32'h000003FC, 2'b00, 1, 1, 2'b00, 8'hFF, 4'd15, 0, 17, 1);
    send(32'h00000101, 2'b00, 1, 0, 2'b00, 8'h00, 4'd0,  0, 17, 1);
    send(32'hFFFFFF00, 2'b01, 1, 1, 2'b01, 8'hFF, 4'd0,  1, 18, 1);
    send(32'hFFFFFFFF, 2'b10, 0, 1, 2'b10, 8'h01, 4'd0,  0, 18, 1);
    send(32'hFFFFFF00, 2'b11, 1, 0, 2'b00, 8'h00, 4'd0,  0, 17, 1);
    send(32'h00000000, 2'b00, 1, 1, 2'b00, 8'h00, 4'd0,  1, 2,  1);
    send(32'h0000F000, 2'b00, 1, 1, 2'b00, 8'h0F, 4'd10, 0, 12, 1);
    send(32'h80000000, 2'b10, 0, 1, 2'b00, 8'h02, 4'd1,  1, 3,  1);
    send(32'hFFFFFFFF, 2'b01, 1, 1, 2'b01, 8'h00, 4'd0,  1, 18, 1);

    // Backpressure: result must hold, in_valid pulses ignored.
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 0;
    send(32'h000000AB, 2'b00, 0, 1, 2'b00, 8'hAB, 4'd0, 0, 2, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_value = 32'h00000055;
      in_mode  = 2'b00;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    chk("bp_still_valid", out_valid, 1);
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("ready_after_release", in_ready, 1);
    chk("valid_after_release", out_valid, 0);
    send(32'hFF000000, 2'b00, 1, 1, 2'b00, 8'hFF, 4'd4, 1, 6, 1);

    // Reset in the middle of a search discards the request.
    send(32'h00000101, 2'b00, 1, 0, 2'b00, 8'h00, 4'd0, 0, 17, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1 rst = 0;
    send(32'h000000FF, 2'b00, 0, 1, 2'b00, 8'hFF, 4'd0, 0, 2, 1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
